// File: rtl/mem_arb_pkg.sv
// Shared types and default constants for the data_mem port arbiter.
// Optional feature macro used by mem_arbiter: MEM_ARB_FAIR_EN.
package mem_arb_pkg;

    typedef enum logic [1:0] {GNT_NONE, GNT_C, GNT_D} gnt_e;

    localparam logic [63:0] DEF_DATA_START = 64'h1000_0000;
    localparam logic [63:0] DEF_DATA_WORDS = 64'h1000;

    typedef struct packed {
        logic [63:0] addr;
        logic [63:0] wdata;
        logic        word_we;
        logic        byte_we;
    } mem_req_t;

    function automatic logic addr_in_range(input logic [63:0] addr,
                                           input logic [63:0] start,
                                           input logic [63:0] words);
        return (addr >= start) && (addr < start + words);
    endfunction

endpackage

// File: rtl/mem_arb_rsp.sv
// Per-port registered response: one-cycle rsp_valid pulse with captured rdata/err.
module mem_arb_rsp (
    input  logic        clk,
    input  logic        reset,
    input  logic        cap,
    input  logic [63:0] rdata_in,
    input  logic        err_in,
    output logic        rsp_valid,
    output logic [63:0] rdata,
    output logic        err
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_valid <= 1'b0;
            rdata     <= '0;
            err       <= 1'b0;
        end else begin
            rsp_valid <= cap;
            if (cap) begin
                rdata <= rdata_in;
                err   <= err_in;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Fixed-priority (C over D) arbiter for the data_mem data port.
// Define MEM_ARB_FAIR_EN to add the port D starvation guard.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter logic [63:0] DATA_START   = DEF_DATA_START,
    parameter logic [63:0] DATA_WORDS   = DEF_DATA_WORDS,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        c_req_valid,
    output logic        c_req_ready,
    input  logic [63:0] c_addr,
    input  logic [63:0] c_wdata,
    input  logic        c_word_we,
    input  logic        c_byte_we,
    output logic        c_rsp_valid,
    output logic [63:0] c_rdata,
    output logic        c_rsp_err,

    input  logic        d_req_valid,
    output logic        d_req_ready,
    input  logic [63:0] d_addr,
    input  logic [63:0] d_wdata,
    input  logic        d_word_we,
    input  logic        d_byte_we,
    output logic        d_rsp_valid,
    output logic [63:0] d_rdata,
    output logic        d_rsp_err,

    output logic [63:0] mem_addr,
    output logic [63:0] mem_data_in,
    output logic        mem_word_we,
    output logic        mem_byte_we,
    input  logic [63:0] mem_data_out
);

    if (STARVE_LIMIT == 0) begin : g_bad_limit
        $error("STARVE_LIMIT must be nonzero");
    end

    gnt_e        gnt;
    mem_req_t    sel;
    logic        force_d;
    logic        addr_ok;
    logic [63:0] rsp_rdata;

    // Reset low blocks every grant, which also kills the write enables and readys.
    always_comb begin
        gnt = GNT_NONE;
        if (!reset)
            gnt = GNT_NONE;
        else if (c_req_valid && !force_d)
            gnt = GNT_C;
        else if (d_req_valid)
            gnt = GNT_D;
    end

    assign c_req_ready = (gnt == GNT_C);
    assign d_req_ready = (gnt == GNT_D);

    always_comb begin
        sel = '0;
        case (gnt)
            GNT_C:   sel = '{addr: c_addr, wdata: c_wdata, word_we: c_word_we, byte_we: c_byte_we};
            GNT_D:   sel = '{addr: d_addr, wdata: d_wdata, word_we: d_word_we, byte_we: d_byte_we};
            default: sel = '0;
        endcase
    end

    assign addr_ok     = addr_in_range(sel.addr, DATA_START, DATA_WORDS);
    assign mem_addr    = sel.addr;
    assign mem_data_in = sel.wdata;
    assign mem_word_we = addr_ok && sel.word_we;
    assign mem_byte_we = addr_ok && sel.byte_we && !sel.word_we;
    assign rsp_rdata   = addr_ok ? mem_data_out : '0;

`ifdef MEM_ARB_FAIR_EN
    localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);

    logic [CW-1:0] starve_cnt;

    assign force_d = d_req_valid && (starve_cnt == CW'(STARVE_LIMIT));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            starve_cnt <= '0;
        else if (!d_req_valid || gnt == GNT_D)
            starve_cnt <= '0;
        else if (gnt == GNT_C && starve_cnt != CW'(STARVE_LIMIT))
            starve_cnt <= starve_cnt + 1'b1;
    end
`else
    assign force_d = 1'b0;
`endif

    mem_arb_rsp u_c_rsp (
        .clk      (clk),
        .reset    (reset),
        .cap      (gnt == GNT_C),
        .rdata_in (rsp_rdata),
        .err_in   (!addr_ok),
        .rsp_valid(c_rsp_valid),
        .rdata    (c_rdata),
        .err      (c_rsp_err)
    );

    mem_arb_rsp u_d_rsp (
        .clk      (clk),
        .reset    (reset),
        .cap      (gnt == GNT_D),
        .rdata_in (rsp_rdata),
        .err_in   (!addr_ok),
        .rsp_valid(d_rsp_valid),
        .rdata    (d_rdata),
        .err      (d_rsp_err)
    );

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter; starvation expectations follow MEM_ARB_FAIR_EN.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        c_req_valid, c_req_ready, c_word_we, c_byte_we;
    logic [63:0] c_addr, c_wdata, c_rdata;
    logic        c_rsp_valid, c_rsp_err;
    logic        d_req_valid, d_req_ready, d_word_we, d_byte_we;
    logic [63:0] d_addr, d_wdata, d_rdata;
    logic        d_rsp_valid, d_rsp_err;
    logic [63:0] mem_addr, mem_data_in, mem_data_out;
    logic        mem_word_we, mem_byte_we;

    always #5 clk = ~clk;

    mem_arbiter #(.DATA_START(64'h1000_0000), .DATA_WORDS(64'h1000), .STARVE_LIMIT(4)) dut (
        .clk(clk), .reset(reset),
        .c_req_valid(c_req_valid), .c_req_ready(c_req_ready), .c_addr(c_addr),
        .c_wdata(c_wdata), .c_word_we(c_word_we), .c_byte_we(c_byte_we),
        .c_rsp_valid(c_rsp_valid), .c_rdata(c_rdata), .c_rsp_err(c_rsp_err),
        .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_word_we(d_word_we), .d_byte_we(d_byte_we),
        .d_rsp_valid(d_rsp_valid), .d_rdata(d_rdata), .d_rsp_err(d_rsp_err),
        .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_word_we(mem_word_we),
        .mem_byte_we(mem_byte_we), .mem_data_out(mem_data_out)
    );

    typedef struct packed {
        logic [63:0] rdata;
        logic        err;
    } rsp_t;

    rsp_t c_q[$];
    rsp_t d_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive_c(input logic v, input logic [63:0] a, input logic [63:0] w,
                           input logic wwe, input logic bwe);
        c_req_valid = v; c_addr = a; c_wdata = w; c_word_we = wwe; c_byte_we = bwe;
    endtask

    task automatic drive_d(input logic v, input logic [63:0] a, input logic [63:0] w,
                           input logic wwe, input logic bwe);
        d_req_valid = v; d_addr = a; d_wdata = w; d_word_we = wwe; d_byte_we = bwe;
    endtask

    // Called 1 time unit after a posedge with inputs already driven; ends 1 unit after the next posedge.
    task automatic expect_cycle(input string tag, input logic er_c, input logic er_d,
                                input logic [63:0] e_addr, input logic [63:0] e_wdata,
                                input logic e_wwe, input logic e_bwe, input logic e_err);
        #1;
        chk({tag, " c_ready"}, c_req_ready, er_c);
        chk({tag, " d_ready"}, d_req_ready, er_d);
        chk({tag, " mem_addr"}, mem_addr, e_addr);
        chk({tag, " mem_word_we"}, mem_word_we, e_wwe);
        chk({tag, " mem_byte_we"}, mem_byte_we, e_bwe);
        if (er_c || er_d)
            chk({tag, " mem_data_in"}, mem_data_in, e_wdata);
        if (er_c) c_q.push_back('{rdata: (e_err ? 64'h0 : mem_data_out), err: e_err});
        if (er_d) d_q.push_back('{rdata: (e_err ? 64'h0 : mem_data_out), err: e_err});
        @(posedge clk);
        #1;
    endtask

    initial begin : monitor
        rsp_t e;
        forever begin
            @(negedge clk);
            if (c_rsp_valid) begin
                if (c_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL c_rsp_unexpected actual=1 required=0");
                end else begin
                    e = c_q.pop_front();
                    chk("c_rdata", c_rdata, e.rdata);
                    chk("c_rsp_err", c_rsp_err, e.err);
                end
            end
            if (d_rsp_valid) begin
                if (d_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL d_rsp_unexpected actual=1 required=0");
                end else begin
                    e = d_q.pop_front();
                    chk("d_rdata", d_rdata, e.rdata);
                    chk("d_rsp_err", d_rsp_err, e.err);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        reset = 1'b0;
        drive_c(1'b1, 64'h1000_0020, 64'h55, 1'b1, 1'b0);
        drive_d(1'b1, 64'h1000_0028, 64'h66, 1'b1, 1'b0);
        mem_data_out = 64'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst c_rsp_valid", c_rsp_valid, 0);
        chk("rst c_rdata", c_rdata, 0);
        chk("rst c_rsp_err", c_rsp_err, 0);
        chk("rst d_rsp_valid", d_rsp_valid, 0);
        chk("rst d_rdata", d_rdata, 0);
        chk("rst d_rsp_err", d_rsp_err, 0);
        chk("rst c_ready", c_req_ready, 0);
        chk("rst d_ready", d_req_ready, 0);
        chk("rst mem_word_we", mem_word_we, 0);
        drive_c(1'b0, 64'h0, 64'h0, 1'b0, 1'b0);
        drive_d(1'b0, 64'h0, 64'h0, 1'b0, 1'b0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        drive_c(1'b1, 64'h1000_0008, 64'h0, 1'b0, 1'b0);
        mem_data_out = 64'hDEAD_BEEF;
        expect_cycle("c_read", 1, 0, 64'h1000_0008, 64'h0, 0, 0, 0);

        drive_c(1'b0, 64'h0, 64'h0, 1'b0, 1'b0);
        expect_cycle("idle", 0, 0, 64'h0, 64'h0, 0, 0, 0);

        drive_d(1'b1, 64'h1000_0100, 64'hCAFE_0001, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive_c(1'b1, 64'h1000_0040 + 64'(i * 8), 64'h0, 1'b0, 1'b0);
            mem_data_out = 64'hA000 + 64'(i);
            expect_cycle("contend", 1, 0, 64'h1000_0040 + 64'(i * 8), 64'h0, 0, 0, 0);
        end
        drive_c(1'b0, 64'h0, 64'h0, 1'b0, 1'b0);
        mem_data_out = 64'h1111;
        expect_cycle("d_after", 0, 1, 64'h1000_0100, 64'hCAFE_0001, 1, 0, 0);

        drive_d(1'b1, 64'h0FFF_FFF8, 64'h77, 1'b1, 1'b0);
        mem_data_out = 64'h1234;
        expect_cycle("d_oor_write", 0, 1, 64'h0FFF_FFF8, 64'h77, 0, 0, 1);
        drive_d(1'b0, 64'h0, 64'h0, 1'b0, 1'b0);

        drive_c(1'b1, 64'h1000_0010, 64'h88, 1'b1, 1'b1);
        mem_data_out = 64'h2222;
        expect_cycle("word_wins", 1, 0, 64'h1000_0010, 64'h88, 1, 0, 0);

        drive_c(1'b1, 64'h1000_0018, 64'h99, 1'b0, 1'b1);
        mem_data_out = 64'h3333;
        expect_cycle("byte_write", 1, 0, 64'h1000_0018, 64'h99, 0, 1, 0);

        drive_c(1'b1, 64'h1000_0FFF, 64'h0, 1'b0, 1'b0);
        mem_data_out = 64'h4444;
        expect_cycle("last_addr", 1, 0, 64'h1000_0FFF, 64'h0, 0, 0, 0);

        drive_c(1'b0, 64'h0, 64'h0, 1'b0, 1'b0);
        drive_d(1'b1, 64'h1000_1000, 64'h0, 1'b0, 1'b0);
        mem_data_out = 64'h5555;
        expect_cycle("d_past_end", 0, 1, 64'h1000_1000, 64'h0, 0, 0, 1);
        drive_d(1'b0, 64'h0, 64'h0, 1'b0, 1'b0);

        drive_c(1'b1, 64'h1000_1000, 64'hAB, 1'b0, 1'b1);
        expect_cycle("c_oor_byte", 1, 0, 64'h1000_1000, 64'hAB, 0, 0, 1);

        drive_c(1'b0, 64'h0, 64'h0, 1'b0, 1'b0);
        expect_cycle("idle2", 0, 0, 64'h0, 64'h0, 0, 0, 0);

        drive_c(1'b1, 64'h1000_0200, 64'h0, 1'b0, 1'b0);
        drive_d(1'b1, 64'h1000_0300, 64'h0, 1'b0, 1'b0);
        mem_data_out = 64'h6666;
`ifdef MEM_ARB_FAIR_EN
        for (int i = 0; i < 4; i++)
            expect_cycle("starve_c", 1, 0, 64'h1000_0200, 64'h0, 0, 0, 0);
        expect_cycle("starve_forced_d", 0, 1, 64'h1000_0300, 64'h0, 0, 0, 0);
        expect_cycle("starve_c_again", 1, 0, 64'h1000_0200, 64'h0, 0, 0, 0);
`else
        for (int i = 0; i < 6; i++)
            expect_cycle("strict_c", 1, 0, 64'h1000_0200, 64'h0, 0, 0, 0);
`endif
        drive_c(1'b0, 64'h0, 64'h0, 1'b0, 1'b0);
        drive_d(1'b0, 64'h0, 64'h0, 1'b0, 1'b0);
        expect_cycle("idle3", 0, 0, 64'h0, 64'h0, 0, 0, 0);

        drive_c(1'b1, 64'h1000_0020, 64'hBAD, 1'b1, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        chk("rstmid mem_word_we", mem_word_we, 0);
        chk("rstmid c_ready", c_req_ready, 0);
        @(posedge clk);
        #1;
        drive_c(1'b0, 64'h0, 64'h0, 1'b0, 1'b0);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("rstmid c_rsp_valid", c_rsp_valid, 0);

        drive_c(1'b1, 64'h1000_0030, 64'h0, 1'b0, 1'b0);
        mem_data_out = 64'h7777;
        expect_cycle("post_reset", 1, 0, 64'h1000_0030, 64'h0, 0, 0, 0);
        drive_c(1'b0, 64'h0, 64'h0, 1'b0, 1'b0);

        repeat (3) @(posedge clk);
        chk("c_q_drained", 64'(c_q.size()), 0);
        chk("d_q_drained", 64'(d_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
